// File: rtl/adpll_pkg.sv
// Shared definitions for the gear-shifting ADPLL loop filter: gear encoding,
// default widths/thresholds and a signed saturation helper.
package adpll_pkg;

  typedef enum logic {
    GEAR_ACQ = 1'b0,
    GEAR_TRK = 1'b1
  } gear_e;

  localparam int unsigned DEF_ERROR_WIDTH   = 8;
  localparam int unsigned DEF_DCO_CC_WIDTH  = 8;
  localparam int unsigned DEF_GAIN_WIDTH    = 8;
  localparam int unsigned DEF_FRAC_BITS     = 6;
  localparam int unsigned DEF_ACC_WIDTH     = 24;
  localparam int unsigned DEF_LOCK_THRESH   = 2;
  localparam int unsigned DEF_LOCK_COUNT    = 16;
  localparam int unsigned DEF_UNLOCK_THRESH = 8;

  // Clamp a 64-bit signed value into the signed range of a w-bit word (w <= 63).
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock counter and ACQUIRE/TRACK gear FSM; advances only on sample strobes,
// with force returning to ACQUIRE at any time.
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH   = DEF_ERROR_WIDTH,
  parameter int unsigned LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned UNLOCK_THRESH = DEF_UNLOCK_THRESH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ERROR_WIDTH:0] err_abs_i,
  input  logic                 strobe_i,
  input  logic                 force_i,
  output gear_e                gear_o,
  output logic                 locked_o
);

  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
  localparam logic [ERROR_WIDTH:0] LOCK_T   = (ERROR_WIDTH + 1)'(LOCK_THRESH);
  localparam logic [ERROR_WIDTH:0] UNLOCK_T = (ERROR_WIDTH + 1)'(UNLOCK_THRESH);
  localparam logic [CW-1:0]        LOCK_N   = CW'(LOCK_COUNT);

  gear_e         gear_q, gear_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gear_q <= GEAR_ACQ;
      cnt_q  <= '0;
    end else begin
      gear_q <= gear_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    gear_d  = gear_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (force_i) begin
      gear_d = GEAR_ACQ;
      cnt_d  = '0;
    end else if (strobe_i) begin
      unique case (gear_q)
        GEAR_ACQ: begin
          if (err_abs_i <= LOCK_T) begin
            if (cnt_inc == LOCK_N) begin
              gear_d = GEAR_TRK;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        GEAR_TRK: begin
          if (err_abs_i > UNLOCK_T) gear_d = GEAR_ACQ;
        end
        default: gear_d = GEAR_ACQ;
      endcase
    end
  end

  assign gear_o   = gear_q;
  assign locked_o = (gear_q == GEAR_TRK);

endmodule

// File: rtl/adpll_gs_loop_filter.sv
// Sample-gated PI loop filter with ACQUIRE/TRACK gain sets, saturating
// integrator with anti-windup and a clamped, registered DCO control code.
module adpll_gs_loop_filter
  import adpll_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH   = DEF_ERROR_WIDTH,
  parameter int unsigned DCO_CC_WIDTH  = DEF_DCO_CC_WIDTH,
  parameter int unsigned GAIN_WIDTH    = DEF_GAIN_WIDTH,
  parameter int unsigned FRAC_BITS     = DEF_FRAC_BITS,
  parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int unsigned LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned UNLOCK_THRESH = DEF_UNLOCK_THRESH
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic                           error_valid_i,
  input  logic [GAIN_WIDTH-1:0]          kp_acq_i,
  input  logic [GAIN_WIDTH-1:0]          ki_acq_i,
  input  logic [GAIN_WIDTH-1:0]          kp_trk_i,
  input  logic [GAIN_WIDTH-1:0]          ki_trk_i,
  input  logic                           freeze_i,
  input  logic                           force_acq_i,
  output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                           dco_cc_valid_o,
  output logic                           locked_o,
  output logic                           sat_o
);

  localparam int unsigned PW = ERROR_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned SW = ACC_WIDTH + 1;

  gear_e                          gear;
  logic [GAIN_WIDTH-1:0]          kp_sel, ki_sel;
  logic signed [PW-1:0]           p_term, i_term;
  logic signed [ACC_WIDTH-1:0]    acc_c;
  logic signed [SW-1:0]           s_sum;
  logic signed [63:0]             cc_w;
  logic                           clamp;
  logic                           err_pos, err_neg, hold_acc;
  logic signed [ERROR_WIDTH:0]    e_ext, e_abs;

  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [DCO_CC_WIDTH-1:0] dco_cc_q, dco_cc_d;
  logic                           sat_q, sat_d;
  logic                           valid_q, valid_d;

  // Magnitude at one extra bit so the most negative error maps cleanly.
  always_comb begin
    e_ext = (ERROR_WIDTH + 1)'(error_i);
    e_abs = e_ext[ERROR_WIDTH] ? -e_ext : e_ext;
  end

  adpll_lock_detect #(
    .ERROR_WIDTH  (ERROR_WIDTH),
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_THRESH(UNLOCK_THRESH)
  ) u_lock (
    .clk      (gen_clk_i),
    .rst      (reset_i),
    .err_abs_i(e_abs),
    .strobe_i (error_valid_i),
    .force_i  (force_acq_i),
    .gear_o   (gear),
    .locked_o (locked_o)
  );

  always_comb begin
    kp_sel = (gear == GEAR_TRK) ? kp_trk_i : ki_sel_dummy_kp();
    ki_sel = (gear == GEAR_TRK) ? ki_trk_i : ki_acq_i;
    p_term = PW'(error_i) * PW'(signed'({1'b0, kp_sel}));
    i_term = PW'(error_i) * PW'(signed'({1'b0, ki_sel}));
    acc_c  = ACC_WIDTH'(sat_s(64'(acc_q) + 64'(i_term), ACC_WIDTH));
    s_sum  = (SW'(p_term) + SW'(acc_c)) >>> FRAC_BITS;
    cc_w   = sat_s(64'(s_sum), DCO_CC_WIDTH);
    clamp  = (cc_w != 64'(s_sum));

    err_neg  = error_i[ERROR_WIDTH-1];
    err_pos  = !error_i[ERROR_WIDTH-1] && (error_i != '0);
    // Integrator holds only when pushing further into the clamp it already hit.
    hold_acc = freeze_i
             || (clamp && !s_sum[SW-1] && err_pos)
             || (clamp &&  s_sum[SW-1] && err_neg);

    acc_d    = acc_q;
    dco_cc_d = dco_cc_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    if (error_valid_i) begin
      acc_d    = hold_acc ? acc_q : acc_c;
      dco_cc_d = DCO_CC_WIDTH'(cc_w);
      sat_d    = clamp;
      valid_d  = 1'b1;
    end
  end

  function automatic logic [GAIN_WIDTH-1:0] ki_sel_dummy_kp();
    return kp_acq_i;
  endfunction

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      dco_cc_q <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      dco_cc_q <= dco_cc_d;
      sat_q    <= sat_d;
      valid_q  <= valid_d;
    end
  end

  assign dco_cc_o       = dco_cc_q;
  assign sat_o          = sat_q;
  assign dco_cc_valid_o = valid_q;

endmodule

// File: tb/tb_adpll_gs_loop_filter.sv
// Scoreboard bench: stimulus pushes model-predicted results, a negedge monitor
// pops them on each dco_cc_valid_o pulse and checks outputs hold otherwise.
module tb_adpll_gs_loop_filter;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] error_i;
  logic              valid_i;
  logic [7:0]        kp_acq, ki_acq, kp_trk, ki_trk;
  logic              freeze, force_acq;
  logic signed [7:0] dco_cc;
  logic              cc_valid, locked, sat;

  adpll_gs_loop_filter dut (
    .gen_clk_i     (clk),
    .reset_i       (rst),
    .error_i       (error_i),
    .error_valid_i (valid_i),
    .kp_acq_i      (kp_acq),
    .ki_acq_i      (ki_acq),
    .kp_trk_i      (kp_trk),
    .ki_trk_i      (ki_trk),
    .freeze_i      (freeze),
    .force_acq_i   (force_acq),
    .dco_cc_o      (dco_cc),
    .dco_cc_valid_o(cc_valid),
    .locked_o      (locked),
    .sat_o         (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint cc;
    bit     sat;
    bit     lk;
  } exp_t;

  exp_t   sbq[$];
  int     total = 0;
  int     bad   = 0;
  longint last_cc = 0;
  bit     last_sat = 1'b0;

  // Reference model state
  longint m_acc  = 0;
  bit     m_trk  = 1'b0;
  int     m_cnt  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint clampv(input longint x, input longint lo, input longint hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  task automatic model_step(input bit v, input int e, input bit frz, input bit frc);
    longint kp, ki, p, accc, s, cc, ab;
    exp_t   x;
    if (v) begin
      kp   = m_trk ? longint'(kp_trk) : longint'(kp_acq);
      ki   = m_trk ? longint'(ki_trk) : longint'(ki_acq);
      p    = e * kp;
      accc = clampv(m_acc + e * ki, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
      s    = (p + accc) >>> 6;
      cc   = clampv(s, -128, 127);
      if (!(frz || (s > 127 && e > 0) || (s < -128 && e < 0))) m_acc = accc;
      ab = (e < 0) ? -e : e;
      if (frc) begin
        m_trk = 1'b0; m_cnt = 0;
      end else if (!m_trk) begin
        if (ab <= 2) m_cnt++; else m_cnt = 0;
        if (m_cnt == 16) begin m_trk = 1'b1; m_cnt = 0; end
      end else if (ab > 8) begin
        m_trk = 1'b0;
      end
      x.cc = cc; x.sat = (cc != s); x.lk = m_trk;
      sbq.push_back(x);
    end else if (frc) begin
      m_trk = 1'b0; m_cnt = 0;
    end
  endtask

  // Called at posedge+1; inputs are sampled by the following edge.
  task automatic step(input bit v, input int e, input bit frz = 1'b0, input bit frc = 1'b0);
    valid_i   = v;
    error_i   = 8'(e);
    freeze    = frz;
    force_acq = frc;
    model_step(v, e, frz, frc);
    @(posedge clk); #1;
    valid_i = 1'b0; freeze = 1'b0; force_acq = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    sbq.delete();
    m_acc = 0; m_trk = 1'b0; m_cnt = 0;
    last_cc = 0; last_sat = 1'b0;
    #1;
    chk("rst_cc", longint'(dco_cc), 0);
    chk("rst_valid", longint'(cc_valid), 0);
    chk("rst_locked", longint'(locked), 0);
    chk("rst_sat", longint'(sat), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cc_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          chk("dco_cc", longint'(dco_cc), x.cc);
          chk("sat", longint'(sat), longint'(x.sat));
          chk("locked", longint'(locked), longint'(x.lk));
          last_cc = x.cc; last_sat = x.sat;
        end
      end else begin
        chk("hold_cc", longint'(dco_cc), last_cc);
        chk("hold_sat", longint'(sat), longint'(last_sat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; error_i = '0; freeze = 1'b0; force_acq = 1'b0;
    kp_acq = 8'd64; ki_acq = 8'd0; kp_trk = 8'd32; ki_trk = 8'd4;
    @(posedge clk); #1;
    chk("init_cc", longint'(dco_cc), 0);
    chk("init_locked", longint'(locked), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unity P path
    step(1, 5); step(0, 0); step(1, -128); step(0, 0);
    // Clamp
    kp_acq = 8'd255;
    step(1, 127); step(1, -128); step(0, 0);

    // Integrator and anti-windup
    do_reset();
    kp_acq = 8'd0; ki_acq = 8'd64;
    for (int i = 0; i < 14; i++) step(1, 10);
    step(1, -10);
    step(1, 10, 1'b1); step(1, 10, 1'b1);
    step(0, 0);

    // Lock and unlock
    do_reset();
    kp_acq = 8'd64; ki_acq = 8'd0; kp_trk = 8'd32; ki_trk = 8'd4;
    for (int i = 0; i < 15; i++) step(1, 1);
    step(1, 3);
    for (int i = 0; i < 16; i++) step(1, -2);
    step(1, 5); step(1, 8); step(1, 9); step(1, 4);

    // Gating: error toggles without strobe
    for (int i = 0; i < 6; i++) step(0, (i % 2) ? 100 : -100);

    // Force with the 16th in-threshold strobe
    for (int i = 0; i < 15; i++) step(1, 0);
    step(1, 0, 1'b0, 1'b1);
    step(1, 2);

    // Reset mid-run from TRACK with an update pending
    for (int i = 0; i < 16; i++) step(1, 0);
    kp_trk = 8'd200;
    step(1, 1);
    do_reset();
    kp_acq = 8'd64; ki_acq = 8'd0;
    step(1, 5); step(0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int e;
      if (i % 200 == 0) begin
        kp_acq = 8'($urandom); ki_acq = 8'($urandom_range(0, 40));
        kp_trk = 8'($urandom); ki_trk = 8'($urandom_range(0, 20));
      end
      e = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 6)) - 3
                                      : int'($urandom_range(0, 255)) - 128;
      step($urandom_range(0, 3) != 0, e, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end

    step(0, 0); step(0, 0); step(0, 0);
    chk("scoreboard_drained", longint'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
